// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, special instruction
// words and a small alignment helper.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_next_sel.sv
// Next-PC selection: redirect target, sequential pc+4, or hold.
// Also flags a redirect target that is not word aligned.
module pc_next_sel
  import instr_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            inc,
  input  logic            redir,
  output logic [XLEN-1:0] pc_next,
  output logic            misalign
);

  always_comb begin
    misalign = is_misaligned(redirect_pc[1:0]);
    pc_next  = pc;
    if (redir) begin
      pc_next = redirect_pc;
    end else if (inc) begin
      // Wraps modulo 2**XLEN by construction.
      pc_next = pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses an async-read ROM and registers the
// returned word into the IF/ID register. FSM: IDLE -> RUN -> HALT.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 5,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_q,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   instr_out,
  output logic              instr_valid,
  output logic              halted,
  output logic              misalign_err
);

  // Handshake: instr_valid marks instr_out/pc_out as a valid in-path word.
  // stall is the downstream not-ready: while it is high (and no redirect)
  // the IF/ID register and PC hold, so a presented word is never dropped.

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            pc_inc, pc_redir, redir_misaligned, is_ebreak;

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc          (pc_q),
    .redirect_pc (redirect_pc),
    .inc         (pc_inc),
    .redir       (pc_redir),
    .pc_next     (pc_d),
    .misalign    (redir_misaligned)
  );

  assign is_ebreak = (rom_q == XLEN'(INSTR_EBREAK));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE: if (en) state_d = FS_RUN;
      FS_RUN: begin
        if (!en) begin
          state_d = FS_IDLE;
        end else if (redirect && redir_misaligned) begin
          state_d = FS_HALT;
        end else if (!redirect && !stall && is_ebreak) begin
          state_d = FS_HALT;
        end
      end
      FS_HALT: state_d = FS_HALT;
      default: state_d = FS_IDLE;
    endcase
  end

  // Output / datapath control.
  always_comb begin
    pc_inc   = 1'b0;
    pc_redir = 1'b0;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    mis_d    = mis_q;
    if (state_q == FS_RUN && en) begin
      if (redirect && redir_misaligned) begin
        mis_d = 1'b1;
      end else if (redirect) begin
        pc_redir = 1'b1;
      end else if (stall) begin
        valid_d = valid_q;
      end else begin
        instr_d  = rom_q;
        pc_out_d = pc_q;
        valid_d  = 1'b1;
        // EBREAK is presented once and the PC stays on it.
        pc_inc   = !is_ebreak;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= XLEN'(INSTR_NOP);
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
    end
  end

  // ROM depth aliasing is intentional: only the word-index bits are used.
  assign rom_addr     = pc_q[ADDR_W+1:2];
  assign pc_out       = pc_out_q;
  assign instr_out    = instr_q;
  assign instr_valid  = valid_q;
  assign misalign_err = mis_q;
  assign halted       = (state_q == FS_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch wired to a 32-word async-read ROM model, with a
// behavioural reference compared every cycle plus directed literal checks.
module tb_instr_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [4:0]  rom_addr;
  logic [31:0] rom_q, pc_out, instr_out;
  logic        instr_valid, halted, misalign_err;

  always #5 clk = ~clk;

  logic [31:0] rom [32];
  assign rom_q = rom[rom_addr];

  instr_fetch #(.ADDR_W(5), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_run, m_halt, m_mis, m_valid;
  logic [31:0] m_pc, m_pc_out, m_instr;

  function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
    return rom[(byte_addr / 4) % 32];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_halt <= 1'b0; m_mis <= 1'b0; m_valid <= 1'b0;
      m_pc <= 32'h0; m_pc_out <= 32'h0; m_instr <= NOP;
    end else if (m_halt || !m_run) begin
      m_valid <= 1'b0;
      if (!m_halt && en) m_run <= 1'b1;
    end else if (!en) begin
      m_run <= 1'b0; m_valid <= 1'b0;
    end else if (redirect && (redirect_pc % 4 != 0)) begin
      m_halt <= 1'b1; m_mis <= 1'b1; m_valid <= 1'b0;
    end else if (redirect) begin
      m_pc <= redirect_pc; m_valid <= 1'b0;
    end else if (!stall) begin
      m_instr  <= rom_word(m_pc);
      m_pc_out <= m_pc;
      m_valid  <= 1'b1;
      if (rom_word(m_pc) == EBREAK) m_halt <= 1'b1;
      else m_pc <= m_pc + 32'd4;
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      check("rom_addr",     {27'b0, rom_addr},     (m_pc / 4) % 32);
      check("pc_out",       pc_out,                m_pc_out);
      check("instr_out",    instr_out,             m_instr);
      check("instr_valid",  {31'b0, instr_valid},  {31'b0, m_valid});
      check("halted",       {31'b0, halted},       {31'b0, m_halt});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_out"},   pc_out,                32'h0);
    check({tag, "_instr"},    instr_out,             NOP);
    check({tag, "_valid"},    {31'b0, instr_valid},  32'h0);
    check({tag, "_halted"},   {31'b0, halted},       32'h0);
    check({tag, "_misalign"}, {31'b0, misalign_err}, 32'h0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 32; i++) rom[i] = {16'hA5A5, 16'(i)};
    rom[5] = EBREAK;

    // Reset state.
    tick(); tick();
    check_reset_outputs("reset");
    check("reset_rom_addr", {27'b0, rom_addr}, 32'h0);
    rst = 1'b0; en = 1'b1; cmp_on = 1'b1;

    // 1. Sequential fetch: valid one cycle after RUN entry.
    tick();
    check("run_entry_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check("f0_pc", pc_out, 32'h0);
    check("f0_instr", instr_out, 32'hA5A5_0000);
    check("f0_valid", {31'b0, instr_valid}, 32'h1);
    tick();
    check("f1_pc", pc_out, 32'h4);
    tick();
    check("f2_pc", pc_out, 32'h8);
    check("f2_instr", instr_out, 32'hA5A5_0002);

    // 2. Stall three cycles at pc_out=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_out, 32'h8);
      check("stall_valid", {31'b0, instr_valid}, 32'h1);
    end
    stall = 1'b0;
    tick();
    check("post_stall_pc", pc_out, 32'hC);

    // 3. Redirect overrides stall.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    check("flush_valid", {31'b0, instr_valid}, 32'h0);
    check("flush_pc_hold", pc_out, 32'hC);
    stall = 1'b0; redirect = 1'b0;
    tick();
    check("redir_pc", pc_out, 32'h40);
    check("redir_instr", instr_out, 32'hA5A5_0010);
    check("redir_valid", {31'b0, instr_valid}, 32'h1);
    tick();
    check("redir_next_pc", pc_out, 32'h44);

    // 4. Misaligned redirect halts; pc stays at 0x48 (word 18).
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    check("mis_err", {31'b0, misalign_err}, 32'h1);
    check("mis_halted", {31'b0, halted}, 32'h1);
    check("mis_valid", {31'b0, instr_valid}, 32'h0);
    check("mis_rom_addr", {27'b0, rom_addr}, 32'd18);
    redirect_pc = 32'h10; en = 1'b0;
    tick();
    en = 1'b1; redirect = 1'b0;
    tick();
    check("mis_sticky", {31'b0, misalign_err}, 32'h1);
    check("mis_still_halted", {31'b0, halted}, 32'h1);
    check("mis_pc_frozen", {27'b0, rom_addr}, 32'd18);
    rst = 1'b1;
    #1;
    check_reset_outputs("mis_rst");
    @(negedge clk);
    rst = 1'b0;

    // 5. EBREAK at word 5 presented once, then halt.
    tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (instr_valid && pc_out == 32'h14) found = 1'b1;
    end
    check("ebreak_seen", {31'b0, found}, 32'h1);
    check("ebreak_instr", instr_out, EBREAK);
    check("ebreak_halted", {31'b0, halted}, 32'h1);
    tick();
    check("ebreak_valid_drop", {31'b0, instr_valid}, 32'h0);
    en = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0;
    tick(); tick();
    check("ebreak_hold_halt", {31'b0, halted}, 32'h1);
    check("ebreak_hold_valid", {31'b0, instr_valid}, 32'h0);
    en = 1'b1; stall = 1'b0; redirect = 1'b0;

    // 6. Async reset between edges while running.
    rst = 1'b1;
    @(negedge clk);
    rom[5] = 32'hA5A5_0005;
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre_rst_pc", pc_out, 32'h8);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // 7. Forty sequential fetches across the ROM wrap.
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      check("seq_pc", pc_out, 32'(i) * 32'd4);
      check("seq_instr", instr_out, {16'hA5A5, 16'(i % 32)});
      if (i == 31) check("wrap_rom_addr", {27'b0, rom_addr}, 32'h0);
      if (i == 32) begin
        check("wrap_pc_out", pc_out, 32'h80);
        check("wrap_instr", instr_out, 32'hA5A5_0000);
      end
    end

    // Pause with en=0: valid drops, nothing advances.
    en = 1'b0;
    tick();
    check("pause_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check("pause_pc_hold", pc_out, 32'h9C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
